// File: rtl/clk_divider_multi.sv
// Multi-channel programmable 50%-duty clock divider with per-channel tick.
// Define CLKDIV_IMMEDIATE_EN to apply loads at once instead of at period start.
module clk_divider_multi #(
  parameter int NCH      = 2,
  parameter int CHW      = 1,
  parameter int N        = 26,
  parameter int DEF_HALF = 25000000
) (
  input  logic           CLK_50M,
  input  logic           nCLR,
  input  logic [NCH-1:0] En,
  input  logic           DivLoad,
  input  logic [CHW-1:0] DivCh,
  input  logic [N-1:0]   DivVal,
  output logic           DivAck,
  output logic           DivErr,
  output logic [NCH-1:0] CLK_Out,
  output logic [NCH-1:0] Tick
);

  localparam logic [N-1:0] HALF_RST = N'(DEF_HALF);
  localparam logic [CHW:0] NCH_W    = (CHW+1)'(NCH);

  logic           valid;
  logic [NCH-1:0] hit;
  logic [NCH-1:0] term;
  logic [N-1:0]   cnt  [NCH];
  logic [N-1:0]   half [NCH];

`ifndef CLKDIV_IMMEDIATE_EN
  logic [N-1:0]   pend [NCH];
  logic [NCH-1:0] pendv;
  logic [NCH-1:0] apply;
`endif

  // Decode the load request and per-channel terminal/apply conditions.
  always_comb begin
    valid = ({1'b0, DivCh} < NCH_W) && (DivVal != '0);
    hit   = '0;
    term  = '0;
`ifndef CLKDIV_IMMEDIATE_EN
    apply = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      hit[i]  = DivLoad && valid && (DivCh == CHW'(i));
      term[i] = !(cnt[i] < half[i] - N'(1));
`ifndef CLKDIV_IMMEDIATE_EN
      // New half-period takes effect as a fresh low half begins,
      // or straight away while the channel is idle.
      apply[i] = pendv[i] &&
                 (!En[i] || (term[i] && CLK_Out[i]));
`endif
    end
  end

  // One-cycle accept/reject pulse for every load strobe.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      DivAck <= 1'b0;
      DivErr <= 1'b0;
    end else begin
      DivAck <= DivLoad && valid;
      DivErr <= DivLoad && !valid;
    end
  end

  // Per-channel counter, output phase, tick and half-period update.
  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      CLK_Out <= '0;
      Tick    <= '0;
`ifndef CLKDIV_IMMEDIATE_EN
      pendv   <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        cnt[i]  <= '0;
        half[i] <= HALF_RST;
`ifndef CLKDIV_IMMEDIATE_EN
        pend[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_IMMEDIATE_EN
        if (hit[i]) begin
          half[i]    <= DivVal;
          cnt[i]     <= '0;
          CLK_Out[i] <= 1'b0;
          Tick[i]    <= 1'b0;
        end else if (!En[i]) begin
`else
        if (!En[i]) begin
`endif
          cnt[i]     <= '0;
          CLK_Out[i] <= 1'b0;
          Tick[i]    <= 1'b0;
        end else if (!term[i]) begin
          cnt[i]     <= cnt[i] + N'(1);
          Tick[i]    <= 1'b0;
        end else begin
          cnt[i]     <= '0;
          CLK_Out[i] <= ~CLK_Out[i];
          Tick[i]    <= ~CLK_Out[i];
        end
`ifndef CLKDIV_IMMEDIATE_EN
        if (apply[i])
          half[i] <= pend[i];
        if (hit[i]) begin
          pend[i]  <= DivVal;
          pendv[i] <= 1'b1;
        end else if (apply[i]) begin
          pendv[i] <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi.
// NCH=2, CHW=2 (so channels 2/3 are out of range), N=8, DEF_HALF=4.
module tb_clk_divider_multi;

  logic       clk;
  logic       nclr;
  logic [1:0] en;
  logic       div_load;
  logic [1:0] div_ch;
  logic [7:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic [1:0] clk_out;
  logic [1:0] tick;

  int total;
  int bad;

  clk_divider_multi #(
    .NCH(2), .CHW(2), .N(8), .DEF_HALF(4)
  ) dut (
    .CLK_50M(clk),
    .nCLR(nclr),
    .En(en),
    .DivLoad(div_load),
    .DivCh(div_ch),
    .DivVal(div_val),
    .DivAck(div_ack),
    .DivErr(div_err),
    .CLK_Out(clk_out),
    .Tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release just after an edge: next step() is edge e1.
  task automatic do_reset();
    nclr     = 1'b0;
    div_load = 1'b0;
    div_ch   = 2'd0;
    div_val  = 8'd0;
    step();
    nclr = 1'b1;
  endtask

  task automatic test_reset();
    nclr = 1'b0;
    en   = 2'b11;
    div_load = 1'b0;
    div_ch = 2'd0;
    div_val = 8'd0;
    step();
    step();
    total++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      bad++;
      $display("FAIL reset_outs clk_out=%b tick=%b want 00 00",
               clk_out, tick);
    end
    total++;
    if (div_ack !== 1'b0 || div_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs ack=%b err=%b want 0 0",
               div_ack, div_err);
    end
  endtask

  task automatic test_basic();
    logic eo, et;
    do_reset();
    en = 2'b11;
    for (int k = 1; k <= 17; k++) begin
      step();
      eo = ((k / 4) % 2) == 1;
      et = (k % 8) == 4;
      total++;
      if (clk_out !== {eo, eo} || tick !== {et, et}) begin
        bad++;
        $display("FAIL basic k=%0d out=%b tick=%b want %b %b",
                 k, clk_out, tick, {eo, eo}, {et, et});
      end
    end
  endtask

  task automatic test_load_period();
    logic eo, et;
    do_reset();
    en = 2'b11;
    for (int k = 1; k <= 5; k++) step();
    div_load = 1'b1;
    div_ch   = 2'd0;
    div_val  = 8'd2;
    step();
    div_load = 1'b0;
    total++;
    if (div_ack !== 1'b1 || div_err !== 1'b0) begin
      bad++;
      $display("FAIL load_ack ack=%b err=%b want 1 0",
               div_ack, div_err);
    end
    for (int k = 7; k <= 18; k++) begin
      step();
      if (k < 8) eo = 1'b1;
      else eo = (((k - 8) / 2) % 2) == 1;
      et = (k >= 10) && ((k - 10) % 4 == 0);
      total++;
      if (clk_out[0] !== eo || tick[0] !== et) begin
        bad++;
        $display("FAIL load_ch0 k=%0d out=%b tick=%b want %b %b",
                 k, clk_out[0], tick[0], eo, et);
      end
      total++;
      if (tick[1] !== ((k % 8) == 4)) begin
        bad++;
        $display("FAIL load_ch1 k=%0d tick=%b want %b",
                 k, tick[1], (k % 8) == 4);
      end
      if (k == 7) begin
        total++;
        if (div_ack !== 1'b0) begin
          bad++;
          $display("FAIL load_ack_once ack=%b want 0", div_ack);
        end
      end
    end
  endtask

  task automatic test_reject();
    logic [1:0] chs [3];
    logic [7:0] vals [3];
    chs[0] = 2'd0; vals[0] = 8'd0;
    chs[1] = 2'd3; vals[1] = 8'd5;
    chs[2] = 2'd2; vals[2] = 8'd1;
    do_reset();
    en = 2'b11;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      div_load = 1'b1;
      div_ch   = chs[j];
      div_val  = vals[j];
      step();
      total++;
      if (div_err !== 1'b1 || div_ack !== 1'b0) begin
        bad++;
        $display("FAIL reject_%0d err=%b ack=%b want 1 0",
                 j, div_err, div_ack);
      end
    end
    div_load = 1'b0;
    step();
    total++;
    if (div_err !== 1'b0) begin
      bad++;
      $display("FAIL reject_clear err=%b want 0", div_err);
    end
    for (int k = 7; k <= 21; k++) begin
      step();
      total++;
      if (tick !== {2{(k % 8) == 4}}) begin
        bad++;
        $display("FAIL reject_period k=%0d tick=%b want %b",
                 k, tick, {2{(k % 8) == 4}});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e0, e1;
    do_reset();
    en = 2'b11;
    step();
    div_load = 1'b1;
    div_ch   = 2'd1;
    div_val  = 8'd3;
    step();
    total++;
    if (div_ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ack1 ack=%b want 1", div_ack);
    end
    div_val = 8'd6;
    step();
    total++;
    if (div_ack !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ack2 ack=%b want 1", div_ack);
    end
    div_load = 1'b0;
    for (int k = 4; k <= 28; k++) begin
      step();
      e0 = (k % 8) == 4;
      e1 = (k == 4) || (k == 14) || (k == 26);
      total++;
      if (tick !== {e1, e0}) begin
        bad++;
        $display("FAIL b2b_tick k=%0d tick=%b want %b",
                 k, tick, {e1, e0});
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 2'b11;
    for (int k = 1; k <= 5; k++) step();
    en = 2'b01;
    for (int k = 6; k <= 9; k++) begin
      step();
      total++;
      if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
        bad++;
        $display("FAIL en_off k=%0d out=%b tick=%b want 0 0",
                 k, clk_out[1], tick[1]);
      end
    end
    en = 2'b11;
    for (int k = 10; k <= 13; k++) begin
      step();
      total++;
      if (clk_out[1] !== (k == 13) || tick[1] !== (k == 13)) begin
        bad++;
        $display("FAIL en_on k=%0d out=%b tick=%b want %b %b",
                 k, clk_out[1], tick[1], k == 13, k == 13);
      end
      total++;
      if (tick[0] !== (k == 12)) begin
        bad++;
        $display("FAIL en_ch0 k=%0d tick=%b want %b",
                 k, tick[0], k == 12);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 2'b11;
    for (int k = 1; k <= 5; k++) step();
    div_load = 1'b1;
    div_ch   = 2'd0;
    div_val  = 8'd2;
    step();
    div_load = 1'b0;
    #2;
    nclr = 1'b0;
    #1;
    total++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || div_ack !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid out=%b tick=%b ack=%b want 00 00 0",
               clk_out, tick, div_ack);
    end
    step();
    nclr = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      total++;
      if (clk_out[0] !== (((k / 4) % 2) == 1) ||
          tick[0] !== ((k % 8) == 4)) begin
        bad++;
        $display("FAIL rst_after k=%0d out=%b tick=%b want %b %b",
                 k, clk_out[0], tick[0],
                 ((k / 4) % 2) == 1, (k % 8) == 4);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_load_period();
    test_reject();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
